// File: rtl/tlul_pkg.sv
// ---------------------------------------------------------------------------
// tlul_pkg
// Shared TileLink-UL definitions used by the initiator (tlul_master) and the
// memory slave on the 24 MHz domain.
//   - Channel A / Channel D opcode encodings
//   - initiator FSM state encoding
//   - expected_ack(): which D opcode answers a given A opcode
// No ports (package).
// ---------------------------------------------------------------------------
package tlul_pkg;

  localparam int OPCODE_W = 3;
  typedef logic [OPCODE_W-1:0] opcode_t;

  // Channel A request opcodes
  localparam opcode_t OP_GET             = 3'd0;
  localparam opcode_t OP_PUT_FULL        = 3'd1;
  localparam opcode_t OP_PUT_PARTIAL     = 3'd2;
  // Channel D response opcodes
  localparam opcode_t OP_ACCESS_ACK      = 3'd3;
  localparam opcode_t OP_ACCESS_ACK_DATA = 3'd4;

  // log2 of the bus word in bytes; the largest legal transfer size
  localparam int FULL_WORD_SIZE = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  // A Get is answered with data; both Put flavours are answered without.
  function automatic opcode_t expected_ack(input opcode_t a_op);
    return (a_op == OP_GET) ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
  endfunction

endpackage

// File: rtl/tlul_master_if.sv
// ---------------------------------------------------------------------------
// tlul_master_if
// Bundles every handshake/bus signal of the TL-UL initiator:
//   cmd_*  : requester command (valid/ready)
//   rsp_*  : response back to the requester (valid/ready)
//   a_*    : TileLink-UL Channel A (initiator -> responder)
//   d_*    : TileLink-UL Channel D (responder -> initiator)
//   stray_d: sticky flag for D beats that arrived with nothing outstanding
// Modports:
//   master : view of the initiator itself (tlul_master)
//   slave  : view of everything around it (requester + bus responder)
// ---------------------------------------------------------------------------
interface tlul_master_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3
);

  // requester command
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [SIZE_WIDTH-1:0]   cmd_size;
  logic [MASK_WIDTH-1:0]   cmd_mask;
  logic [DATA_WIDTH-1:0]   cmd_data;

  // requester response
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_denied;
  logic                    rsp_error;
  logic                    rsp_timeout;

  // Channel A
  logic                    a_valid;
  logic                    a_ready;
  logic [OPCODE_WIDTH-1:0] a_opcode;
  logic [SIZE_WIDTH-1:0]   a_size;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [MASK_WIDTH-1:0]   a_mask;
  logic [DATA_WIDTH-1:0]   a_data;

  // Channel D
  logic                    d_valid;
  logic                    d_ready;
  logic [OPCODE_WIDTH-1:0] d_opcode;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic                    d_denied;
  logic [DATA_WIDTH-1:0]   d_data;

  logic                    stray_d;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_mask, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_denied, rsp_error, rsp_timeout,
    input  rsp_ready,
    output a_valid, a_opcode, a_size, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_denied, d_data,
    output d_ready,
    output stray_d
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_mask, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_denied, rsp_error, rsp_timeout,
    output rsp_ready,
    input  a_valid, a_opcode, a_size, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_denied, d_data,
    input  d_ready,
    input  stray_d
  );

endinterface

// File: rtl/tlul_align_check.sv
// ---------------------------------------------------------------------------
// tlul_align_check
// Purely combinational classification of an incoming command.
// Ports:
//   addr_lsb   in  2           two low byte-address bits of the command
//   size       in  SIZE_WIDTH  log2 of the transfer size in bytes
//   mask       in  MASK_WIDTH  byte enables of the command
//   misaligned out 1           transfer not naturally aligned or too large
//   full_word  out 1           whole-word transfer with every byte enabled
// ---------------------------------------------------------------------------
module tlul_align_check
  import tlul_pkg::*;
#(
  parameter int SIZE_WIDTH = 3,
  parameter int MASK_WIDTH = 4
) (
  input  logic [1:0]            addr_lsb,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [MASK_WIDTH-1:0] mask,
  output logic                  misaligned,
  output logic                  full_word
);

  // Natural alignment: a 2^size byte transfer needs its low size address
  // bits clear. Anything wider than one bus word can never be legal.
  always_comb begin
    misaligned = 1'b0;
    full_word  = 1'b0;
    case (size)
      SIZE_WIDTH'(0): misaligned = 1'b0;
      SIZE_WIDTH'(1): misaligned = addr_lsb[0];
      SIZE_WIDTH'(2): misaligned = |addr_lsb;
      default:        misaligned = 1'b1;
    endcase
    full_word = (size == SIZE_WIDTH'(FULL_WORD_SIZE)) && (&mask);
  end

endmodule

// File: rtl/tlul_master.sv
// ---------------------------------------------------------------------------
// tlul_master
// TileLink-UL initiator with a single outstanding transaction. Turns one
// requester command into a Channel-A request and hands the matching
// Channel-D beat back as a response. Misaligned commands are rejected
// locally, and a response timeout keeps a silent responder from stalling
// the requester.
// Ports:
//   clk_24  in  1   24 MHz clock
//   rst     in  1   asynchronous active-high reset
//   bus     master  tlul_master_if: cmd_*, rsp_*, a_*, d_*, stray_d
// Every output is either a register or a decode of the state register.
// ---------------------------------------------------------------------------
module tlul_master
  import tlul_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MASK_WIDTH     = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH     = 3,
  parameter int OPCODE_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk_24,
  input  logic          rst,
  tlul_master_if.master bus
);

  localparam int                 CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [CNT_WIDTH-1:0]    wait_cnt;

  logic [OPCODE_WIDTH-1:0] a_opcode_q;
  logic [SIZE_WIDTH-1:0]   a_size_q;
  logic [ADDR_WIDTH-1:0]   a_address_q;
  logic [MASK_WIDTH-1:0]   a_mask_q;
  logic [DATA_WIDTH-1:0]   a_data_q;

  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_denied_q;
  logic                    rsp_error_q;
  logic                    rsp_timeout_q;
  logic                    stray_q;

  logic                    misaligned;
  logic                    full_word;
  logic                    d_bad_opcode;
  logic                    d_keep_data;
  logic                    unused_d_size;

  // The beat size on D carries no information we act on for single words.
  assign unused_d_size = ^bus.d_size;

  tlul_align_check #(
    .SIZE_WIDTH (SIZE_WIDTH),
    .MASK_WIDTH (MASK_WIDTH)
  ) u_align_check (
    .addr_lsb   (bus.cmd_addr[1:0]),
    .size       (bus.cmd_size),
    .mask       (bus.cmd_mask),
    .misaligned (misaligned),
    .full_word  (full_word)
  );

  // Judge the incoming D beat against the request still held on A: a wrong
  // ack type is an error, and read data is only passed on for a clean,
  // non-denied AccessAckData.
  always_comb begin
    d_bad_opcode = 1'b0;
    d_keep_data  = 1'b0;
    d_bad_opcode = (bus.d_opcode != OPCODE_WIDTH'(expected_ack(opcode_t'(a_opcode_q))));
    d_keep_data  = !d_bad_opcode && !bus.d_denied &&
                   (bus.d_opcode == OPCODE_WIDTH'(OP_ACCESS_ACK_DATA));
  end

  // Main transaction FSM. The A fields are loaded once at the command
  // handshake and left untouched until the next command, so they are
  // trivially stable for as long as a_valid is up. The response registers
  // are loaded on the way into RESP and cleared on the way out.
  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      a_opcode_q    <= '0;
      a_size_q      <= '0;
      a_address_q   <= '0;
      a_mask_q      <= '0;
      a_data_q      <= '0;
      rsp_data_q    <= '0;
      rsp_denied_q  <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Nothing is outstanding, so any D beat here is late or spurious.
          if (bus.d_valid) begin
            stray_q <= 1'b1;
          end
          if (bus.cmd_valid) begin
            a_size_q    <= bus.cmd_size;
            a_address_q <= bus.cmd_addr;
            if (bus.cmd_write) begin
              a_opcode_q <= full_word ? OPCODE_WIDTH'(OP_PUT_FULL)
                                      : OPCODE_WIDTH'(OP_PUT_PARTIAL);
              a_mask_q   <= bus.cmd_mask;
              a_data_q   <= bus.cmd_data;
            end else begin
              a_opcode_q <= OPCODE_WIDTH'(OP_GET);
              a_mask_q   <= '1;
              a_data_q   <= '0;
            end
            if (misaligned) begin
              state         <= RESP;
              rsp_data_q    <= '0;
              rsp_denied_q  <= 1'b0;
              rsp_error_q   <= 1'b1;
              rsp_timeout_q <= 1'b0;
            end else begin
              state <= REQ;
            end
          end
        end

        REQ: begin
          if (bus.a_ready) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end

        WAIT: begin
          // A beat arriving on the expiry cycle still counts as an answer.
          if (bus.d_valid) begin
            state         <= RESP;
            rsp_data_q    <= d_keep_data ? bus.d_data : '0;
            rsp_denied_q  <= bus.d_denied;
            rsp_error_q   <= d_bad_opcode;
            rsp_timeout_q <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            state         <= RESP;
            rsp_data_q    <= '0;
            rsp_denied_q  <= 1'b0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            rsp_data_q    <= '0;
            rsp_denied_q  <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure state decodes; D is only accepted when a
  // beat is expected (WAIT) or must be drained (IDLE).
  assign bus.cmd_ready   = (state == IDLE);
  assign bus.a_valid     = (state == REQ);
  assign bus.d_ready     = (state == IDLE) || (state == WAIT);
  assign bus.rsp_valid   = (state == RESP);

  assign bus.a_opcode    = a_opcode_q;
  assign bus.a_size      = a_size_q;
  assign bus.a_address   = a_address_q;
  assign bus.a_mask      = a_mask_q;
  assign bus.a_data      = a_data_q;

  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_denied  = rsp_denied_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.stray_d     = stray_q;

endmodule

// File: tb/tb_tlul_master.sv
// ---------------------------------------------------------------------------
// tb_tlul_master
// Self-checking bench for tlul_master with TIMEOUT_CYCLES = 8. The bench acts
// as requester and as Channel-D responder. Expected responses are pushed to
// a scoreboard queue as each command is driven and popped when the response
// appears.
// ---------------------------------------------------------------------------
module tb_tlul_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int SW = 3;
  localparam int OW = 3;
  localparam int TO = 8;

  localparam logic [2:0] GET         = 3'd0;
  localparam logic [2:0] PUT_FULL    = 3'd1;
  localparam logic [2:0] PUT_PARTIAL = 3'd2;
  localparam logic [2:0] ACK         = 3'd3;
  localparam logic [2:0] ACK_DATA    = 3'd4;

  // data, denied, error, timeout
  typedef struct packed {
    logic [31:0] data;
    logic        denied;
    logic        error;
    logic        timeout;
  } rsp_t;

  logic clk_24 = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  rsp_t exp_r;
  rsp_t obs_r;

  always #21 clk_24 = ~clk_24;

  tlul_master_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .SIZE_WIDTH(SW), .OPCODE_WIDTH(OW)
  ) bus ();

  tlul_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .SIZE_WIDTH(SW), .OPCODE_WIDTH(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_24 (clk_24),
    .rst    (rst),
    .bus    (bus.master)
  );

  assign obs_r = {bus.rsp_data, bus.rsp_denied, bus.rsp_error, bus.rsp_timeout};

  // ---- stimulus helpers (no checking except the command-accept bound) ----
  task automatic tick();
    @(posedge clk_24);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_size  = '0;   bus.cmd_mask  = '0;   bus.cmd_data = '0;
    bus.rsp_ready = 1'b0; bus.a_ready   = 1'b0;
    bus.d_valid   = 1'b0; bus.d_opcode  = '0;   bus.d_size   = '0;
    bus.d_denied  = 1'b0; bus.d_data    = '0;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] addr,
                          input logic [2:0] size, input logic [3:0] mask,
                          input logic [31:0] data);
    int n;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = addr;
    bus.cmd_size  = size; bus.cmd_mask  = mask; bus.cmd_data = data;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_a();
    bus.a_ready = 1'b1;
    tick();
    bus.a_ready = 1'b0;
  endtask

  task automatic send_d(input logic [2:0] op, input logic den, input logic [31:0] data);
    bus.d_valid = 1'b1; bus.d_opcode = op; bus.d_size = 3'd2;
    bus.d_denied = den; bus.d_data = data;
    tick();
    bus.d_valid = 1'b0; bus.d_denied = 1'b0; bus.d_data = '0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (bus.rsp_valid !== 1'b1 && cycles < 32) begin
      tick();
      cycles++;
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic pop_exp();
    if (exp_q.size() > 0) exp_r = exp_q.pop_front();
    else exp_r = 'x;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus.cmd_ready, bus.d_ready, bus.a_valid, bus.rsp_valid} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL reset_handshakes: got %b required 1100",
               {bus.cmd_ready, bus.d_ready, bus.a_valid, bus.rsp_valid});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask, bus.a_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_a_fields: got %h required 0",
               {bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask, bus.a_data});
    end
    checks++;
    if ({obs_r, bus.stray_d, bus.cmd_ready} !== {35'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got %h stray=%b cmd_ready=%b required 0/0/1",
               obs_r, bus.stray_d, bus.cmd_ready);
    end
  endtask

  task automatic test_put_full();
    int lat;
    exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b0});
    send_cmd(1'b1, 32'h4000_0010, 3'd2, 4'hF, 32'hCAFE_F00D);
    checks++;
    if ({bus.a_valid, bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask, bus.a_data} !==
        {1'b1, PUT_FULL, 3'd2, 32'h4000_0010, 4'hF, 32'hCAFE_F00D}) begin
      errors++;
      $display("[TB] FAIL put_full_a: got v=%b op=%0d sz=%0d adr=%h m=%h d=%h required 1/1/2/40000010/f/cafef00d",
               bus.a_valid, bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask, bus.a_data);
    end
    send_a();
    checks++;
    if ({bus.a_valid, bus.d_ready, bus.rsp_valid} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL put_full_wait: got a_valid/d_ready/rsp_valid=%b required 010",
               {bus.a_valid, bus.d_ready, bus.rsp_valid});
    end
    send_d(ACK, 1'b0, 32'hDEAD_BEEF);
    wait_rsp(lat);
    pop_exp();
    checks++;
    if (lat != 0 || obs_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL put_full_rsp: got rsp=%h latency=%0d required rsp=%h latency=0", obs_r, lat, exp_r);
    end
    take_rsp();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL put_full_done: got cmd_ready=%b rsp_valid=%b required 1/0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_get();
    int lat;
    exp_q.push_back({32'hCAFE_F00D, 1'b0, 1'b0, 1'b0});
    send_cmd(1'b0, 32'h4000_0010, 3'd2, 4'h0, 32'h0);
    checks++;
    if ({bus.a_valid, bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask} !==
        {1'b1, GET, 3'd2, 32'h4000_0010, 4'hF}) begin
      errors++;
      $display("[TB] FAIL get_a: got v=%b op=%0d sz=%0d adr=%h m=%h required 1/0/2/40000010/f",
               bus.a_valid, bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask);
    end
    send_a();
    send_d(ACK_DATA, 1'b0, 32'hCAFE_F00D);
    wait_rsp(lat);
    pop_exp();
    checks++;
    if (lat != 0 || obs_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL get_rsp: got rsp=%h latency=%0d required rsp=%h latency=0", obs_r, lat, exp_r);
    end
    take_rsp();
  endtask

  task automatic test_put_partial();
    logic [31:0] addrs [3] = '{32'h4000_0002, 32'h4000_0010, 32'h4000_0013};
    logic [2:0]  sizes [3] = '{3'd1, 3'd2, 3'd0};
    logic [3:0]  masks [3] = '{4'h3, 4'h7, 4'h8};
    int lat;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b0});
      send_cmd(1'b1, addrs[i], sizes[i], masks[i], 32'h1122_3300 + i);
      checks++;
      if ({bus.a_valid, bus.a_opcode, bus.a_size, bus.a_mask, bus.a_data} !==
          {1'b1, PUT_PARTIAL, sizes[i], masks[i], 32'h1122_3300 + i}) begin
        errors++;
        $display("[TB] FAIL put_partial_a[%0d]: got v=%b op=%0d sz=%0d m=%h d=%h required 1/2/%0d/%h/%h",
                 i, bus.a_valid, bus.a_opcode, bus.a_size, bus.a_mask, bus.a_data,
                 sizes[i], masks[i], 32'h1122_3300 + i);
      end
      send_a();
      send_d(ACK, 1'b0, 32'h0);
      wait_rsp(lat);
      pop_exp();
      checks++;
      if (obs_r !== exp_r) begin
        errors++;
        $display("[TB] FAIL put_partial_rsp[%0d]: got %h required %h", i, obs_r, exp_r);
      end
      take_rsp();
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [4] = '{32'h4000_0001, 32'h4000_0002, 32'h4000_0000, 32'h4000_0003};
    logic [2:0]  sizes [4] = '{3'd1, 3'd2, 3'd3, 3'd2};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({32'h0, 1'b0, 1'b1, 1'b0});
      send_cmd(1'b1, addrs[i], sizes[i], 4'h3, 32'hFFFF_FFFF);
      pop_exp();
      checks++;
      if ({bus.a_valid, bus.rsp_valid} !== 2'b01 || obs_r !== exp_r) begin
        errors++;
        $display("[TB] FAIL misaligned[%0d]: got a_valid=%b rsp_valid=%b rsp=%h required 0/1/%h",
                 i, bus.a_valid, bus.rsp_valid, obs_r, exp_r);
      end
      take_rsp();
    end
  endtask

  task automatic test_denied();
    int lat;
    exp_q.push_back({32'h0, 1'b1, 1'b0, 1'b0});
    send_cmd(1'b0, 32'h3000_0000, 3'd2, 4'hF, 32'h0);
    send_a();
    send_d(ACK_DATA, 1'b1, 32'h1234_5678);
    wait_rsp(lat);
    pop_exp();
    checks++;
    if (obs_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL denied_rsp: got %h required %h", obs_r, exp_r);
    end
    take_rsp();
  endtask

  task automatic test_wrong_opcode();
    logic       wr   [2] = '{1'b0, 1'b1};
    logic [2:0] dops [2] = '{ACK, ACK_DATA};
    int lat;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({32'h0, 1'b0, 1'b1, 1'b0});
      send_cmd(wr[i], 32'h4000_0040, 3'd2, 4'hF, 32'h7777_7777);
      send_a();
      send_d(dops[i], 1'b0, 32'h8888_8888);
      wait_rsp(lat);
      pop_exp();
      checks++;
      if (obs_r !== exp_r) begin
        errors++;
        $display("[TB] FAIL wrong_opcode_rsp[%0d]: got %h required %h", i, obs_r, exp_r);
      end
      take_rsp();
    end
  endtask

  task automatic test_a_stall();
    int lat;
    exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b0});
    send_cmd(1'b1, 32'h4000_0100, 3'd2, 4'h5, 32'hA5A5_A5A5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.a_valid, bus.d_ready, bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask, bus.a_data} !==
          {1'b1, 1'b0, PUT_PARTIAL, 3'd2, 32'h4000_0100, 4'h5, 32'hA5A5_A5A5}) begin
        errors++;
        $display("[TB] FAIL a_stall[%0d]: got v=%b dr=%b op=%0d sz=%0d adr=%h m=%h d=%h required 1/0/2/2/40000100/5/a5a5a5a5",
                 i, bus.a_valid, bus.d_ready, bus.a_opcode, bus.a_size, bus.a_address, bus.a_mask, bus.a_data);
      end
      tick();
    end
    send_a();
    send_d(ACK, 1'b0, 32'h0);
    wait_rsp(lat);
    pop_exp();
    checks++;
    if (obs_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL a_stall_rsp: got %h required %h", obs_r, exp_r);
    end
    take_rsp();
  endtask

  task automatic test_timeout();
    int lat;
    exp_q.push_back({32'h0, 1'b0, 1'b1, 1'b1});
    send_cmd(1'b0, 32'h4000_0200, 3'd2, 4'hF, 32'h0);
    send_a();
    wait_rsp(lat);
    pop_exp();
    checks++;
    if (bus.rsp_valid !== 1'b1 || lat != TO || obs_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL timeout_rsp: got rsp_valid=%b latency=%0d rsp=%h required 1/%0d/%h",
               bus.rsp_valid, lat, obs_r, TO, exp_r);
    end
    take_rsp();
  endtask

  task automatic test_timeout_race();
    int lat;
    exp_q.push_back({32'h5555_AAAA, 1'b0, 1'b0, 1'b0});
    send_cmd(1'b0, 32'h4000_0204, 3'd2, 4'hF, 32'h0);
    send_a();
    repeat (TO - 1) tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.d_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL race_pre: got rsp_valid=%b d_ready=%b required 0/1", bus.rsp_valid, bus.d_ready);
    end
    send_d(ACK_DATA, 1'b0, 32'h5555_AAAA);
    pop_exp();
    checks++;
    if (bus.rsp_valid !== 1'b1 || obs_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL race_rsp: got rsp_valid=%b rsp=%h required 1/%h", bus.rsp_valid, obs_r, exp_r);
    end
    take_rsp();
  endtask

  task automatic test_stray();
    checks++;
    if (bus.stray_d !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_before: got %b required 0", bus.stray_d);
    end
    send_d(ACK_DATA, 1'b0, 32'h0BAD_0BAD);
    tick();
    checks++;
    if ({bus.stray_d, bus.cmd_ready, bus.rsp_valid, bus.a_valid} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL stray_after: got stray/cmd_ready/rsp_valid/a_valid=%b required 1100",
               {bus.stray_d, bus.cmd_ready, bus.rsp_valid, bus.a_valid});
    end
  endtask

  task automatic test_rsp_hold();
    int lat;
    exp_q.push_back({32'h0BAD_F00D, 1'b0, 1'b0, 1'b0});
    send_cmd(1'b0, 32'h4000_0300, 3'd2, 4'hF, 32'h0);
    send_a();
    send_d(ACK_DATA, 1'b0, 32'h0BAD_F00D);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.d_ready} !== 3'b100 || obs_r !== exp_q[0]) begin
        errors++;
        $display("[TB] FAIL rsp_hold[%0d]: got valid/cmd_ready/d_ready=%b rsp=%h required 100/%h",
                 i, {bus.rsp_valid, bus.cmd_ready, bus.d_ready}, obs_r, exp_q[0]);
      end
      tick();
    end
    pop_exp();
    take_rsp();
    checks++;
    if (bus.cmd_ready !== 1'b1 || obs_r !== 35'h0) begin
      errors++;
      $display("[TB] FAIL rsp_hold_release: got cmd_ready=%b rsp=%h required 1/0", bus.cmd_ready, obs_r);
    end
  endtask

  task automatic test_back_to_back();
    logic        wr  [2] = '{1'b1, 1'b0};
    logic [2:0]  dop [2] = '{ACK, ACK_DATA};
    int lat;
    exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      send_cmd(wr[i], 32'h4000_0020, 3'd2, 4'hF, 32'h0BAD_CAFE);
      send_a();
      send_d(dop[i], 1'b0, 32'h0BAD_CAFE);
      wait_rsp(lat);
      pop_exp();
      checks++;
      if (lat != 0 || obs_r !== exp_r) begin
        errors++;
        $display("[TB] FAIL b2b_rsp[%0d]: got rsp=%h latency=%0d required %h/0", i, obs_r, lat, exp_r);
      end
      take_rsp();
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_ready[%0d]: got cmd_ready=%b required 1", i, bus.cmd_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit saw_rsp;
    send_cmd(1'b0, 32'h4000_0400, 3'd2, 4'hF, 32'h0);
    send_a();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.a_valid, bus.rsp_valid, bus.stray_d} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_mid: got cmd_ready/a_valid/rsp_valid/stray=%b required 1000",
               {bus.cmd_ready, bus.a_valid, bus.rsp_valid, bus.stray_d});
    end
    tick();
    rst = 1'b0;
    saw_rsp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1 || bus.a_valid === 1'b1) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp) begin
      errors++;
      $display("[TB] FAIL reset_mid_drop: got activity after reset required none");
    end
  endtask

  initial begin
    #(42 * 20000);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_put_full();
    test_get();
    test_put_partial();
    test_misaligned();
    test_denied();
    test_wrong_opcode();
    test_a_stall();
    test_timeout();
    test_stray();
    test_timeout_race();
    test_rsp_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlul_master.md
# tlul_master

TileLink-UL initiator that turns single-word read/write commands from a local requester into Channel-A requests and returns the matching Channel-D response. It sits between a CPU-side or test-sequencer port and the bus, with one transaction outstanding. It is the initiator counterpart of the TL-UL memory slave on the 24 MHz domain. It adds local alignment checking and a response timeout so a silent or hung responder cannot stall the requester.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width
- SIZE_WIDTH, 3, a_size/d_size width (log2 bytes)
- OPCODE_WIDTH, 3, opcode width
- TIMEOUT_CYCLES, 256, cycles allowed in WAIT before timeout (≥2)

Ports:
- clk_24  in  1  single clock, 24 MHz domain
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  requester command valid
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_size  in  SIZE_WIDTH  log2 bytes (0..2)
- cmd_mask  in  MASK_WIDTH  byte enables (writes)
- cmd_data  in  DATA_WIDTH  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  requester takes response
- rsp_data  out  DATA_WIDTH  read data (0 for writes/errors)
- rsp_denied  out  1  responder set d_denied
- rsp_error  out  1  misaligned, timeout, or wrong D opcode
- rsp_timeout  out  1  error cause was timeout
- a_valid, a_opcode, a_size, a_address, a_mask, a_data  out  Channel A
- a_ready  in  1  Channel A ready
- d_valid, d_opcode, d_size, d_denied, d_data  in  Channel D
- d_ready  out  1  Channel D ready
- stray_d  out  1  sticky: a D beat arrived with nothing outstanding

## Operation
- Opcodes: Get=0, PutFullData=1, PutPartialData=2, AccessAck=3, AccessAckData=4.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: cmd_ready=1.
  - On cmd handshake, register all command fields.
  - Misaligned command goes directly to RESP with rsp_error=1 and nothing issued. Misaligned means size 1 with addr[0]≠0, size 2 with addr[1:0]≠0, or size >2.
  - Otherwise go to REQ.
- Opcode selection:
  - Read → Get, a_mask = all ones.
  - Write with mask all ones and size 2 → PutFullData.
  - Any other write → PutPartialData.
- REQ: a_valid=1 with all A fields stable. On a_ready, go to WAIT and clear the timeout counter.
- WAIT: d_ready=1. On d_valid:
  - Capture d_denied and d_data into the response, then go to RESP.
  - rsp_error=1 if d_opcode does not equal the expected ack (Get→AccessAckData, Put→AccessAck).
  - rsp_data = d_data only for AccessAckData with denied=0; otherwise 0.
- WAIT timeout: if the counter reaches TIMEOUT_CYCLES-1 without d_valid, go to RESP with rsp_error=1, rsp_timeout=1, rsp_data=0.
- RESP: rsp_valid=1. On rsp_ready, return to IDLE.
- d_ready is also 1 in IDLE. A D beat accepted in IDLE (a late response after timeout, or spurious) is dropped and sets stray_d. stray_d clears only on reset.
- d_ready is 0 in REQ and RESP.

## Timing
- Reset values: state IDLE; cmd_ready=1; a_valid=0; all A fields 0; d_ready=1; rsp_valid=0; rsp_data=0; rsp flags 0; stray_d=0.
- All outputs are registered or decoded from state. There is no combinational path from any input to any output.
- Cycle timeline:
  - Command handshake at cycle t → a_valid rises at t+1.
  - Against a zero-wait responder, the D beat is seen at t+2 and rsp_valid rises at t+3.
  - Misaligned command → rsp_valid at t+1.
- a_valid never deasserts before a_ready. The A fields do not change while a_valid=1.
- rsp_valid and all rsp_* outputs are held until rsp_ready.
- The next cmd_ready=1 comes the cycle after the rsp handshake, so back-to-back throughput is one transaction per 4 cycles minimum.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits, saturating, and active only in WAIT.
- If d_valid and timeout expiry occur in the same cycle, d_valid wins: normal response, no timeout.
- Asserting rst mid-transaction returns to IDLE immediately and drops the in-flight transaction. No response is produced for it.

## Structure
- Package tlul_pkg: Channel A/D opcode localparams, the state encoding, and a helper for the expected-ack function. The same package is shared with the slave.
- Sub-module tlul_align_check (combinational): takes addr, size, and mask, and produces the misaligned flag and the full-word flag. Everything else stays in one FSM module.

## Test plan
- Write 0x4000_0010, data 0xCAFEF00D, mask 0xF → PutFullData issued, size 2. AccessAck returned → rsp_valid with error=0, denied=0, data=0.
- Read 0x4000_0010 → Get with mask 0xF. AccessAckData returns 0xCAFEF00D → rsp_data=0xCAFEF00D.
- Write with mask 0x3, size 1, to 0x4000_0002 → PutPartialData issued. Same write to 0x4000_0001 → no a_valid, rsp_error=1 at t+1.
- Read 0x3000_0000 answered with denied=1 → rsp_denied=1, rsp_data=0. Read answered with AccessAck instead of AccessAckData → rsp_error=1.
- Hold a_ready=0 for 5 cycles → a_valid and all A fields stay constant. With TIMEOUT_CYCLES=8 and d_valid never asserted → rsp_timeout=1 exactly 8 cycles after the A handshake. A D beat then injected in IDLE → stray_d=1.
- Hold rsp_ready=0 for 3 cycles → rsp outputs stable, cmd_ready=0. Assert rst during WAIT → next cycle state IDLE, a_valid=0, rsp_valid=0.
